// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and the responder state type.
package ahb_lite_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001,
    HBURST_WRAP4  = 3'b010,
    HBURST_INCR4  = 3'b011,
    HBURST_WRAP8  = 3'b100,
    HBURST_INCR8  = 3'b101,
    HBURST_WRAP16 = 3'b110,
    HBURST_INCR16 = 3'b111
  } hburst_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE     = 3'b000,
    HSIZE_HALF     = 3'b001,
    HSIZE_WORD     = 3'b010,
    HSIZE_DWORD    = 3'b011,
    HSIZE_BYTE_16  = 3'b100,
    HSIZE_BYTE_32  = 3'b101,
    HSIZE_BYTE_64  = 3'b110,
    HSIZE_BYTE_128 = 3'b111
  } hsize_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } slv_state_e;

  // True when any address bit below the transfer size is set.
  function automatic logic misaligned(logic [2:0] size, logic [6:0] addr_lo);
    return |(addr_lo & ((7'd1 << size) - 7'd1));
  endfunction

endpackage

// File: rtl/ahb_lane_strobe.sv
// Byte-enable decode: which byte lanes a (size, address) transfer touches.
module ahb_lane_strobe
  import ahb_lite_pkg::*;
#(
  parameter int data_size = 32
) (
  input  logic [2:0]                     size_i,
  input  logic [$clog2(data_size/8)-1:0] addr_i,
  output logic [data_size/8-1:0]         strb_o
);

  localparam int LANES  = data_size / 8;
  localparam int LANE_W = $clog2(LANES);

  // A lane is enabled when it sits in the same size-aligned block as the address.
  always_comb begin
    strb_o = '0;
    for (int i = 0; i < LANES; i++)
      strb_o[i] = ((LANE_W'(i) ^ addr_i) >> size_i) == '0;
  end

endmodule

// File: rtl/ahb_lite_slave_mem.sv
// AHB-Lite responder over a word-organised memory with wait states and ERROR.
module ahb_lite_slave_mem
  import ahb_lite_pkg::*;
#(
  parameter int data_size   = 32,
  parameter int mem_depth   = 256,
  parameter int wait_states = 0
) (
  input  logic                 H_clk,
  input  logic                 H_rst,
  input  logic                 H_sel,
  input  logic                 H_readyIn,
  input  logic [31:0]          H_add,
  input  logic                 H_WR,
  input  logic [2:0]           H_size,
  input  logic [2:0]           H_burst,
  input  logic [1:0]           H_trans,
  input  logic [data_size-1:0] W_data,
  output logic [data_size-1:0] R_data,
  output logic                 H_readyN,
  output logic                 H_rsp
);

  localparam int LANES   = data_size / 8;
  localparam int LANE_W  = $clog2(LANES);
  localparam int IDX_W   = $clog2(mem_depth);
  localparam int BADDR_W = LANE_W + IDX_W;

  slv_state_e           state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [BADDR_W-1:0]   addr_q, addr_d;
  logic                 wr_q, wr_d;
  logic [2:0]           size_q, size_d;
  logic [data_size-1:0] mem_q [mem_depth];

  logic             ready, accept, acc_err;
  logic [LANES-1:0] strb;
  logic [IDX_W-1:0] idx;

  // Burst type carries no meaning here: addresses come from the master each beat.
  logic unused_inputs;
  assign unused_inputs = ^{H_burst, H_trans[0]};

  assign ready   = state_q inside {ST_IDLE, ST_DATA, ST_ERR2};
  assign accept  = H_sel & H_readyIn & H_trans[1] & ready;
  assign acc_err = (H_size > 3'(LANE_W))
                 | misaligned(H_size, H_add[6:0])
                 | (|H_add[31:BADDR_W]);
  assign idx     = addr_q[LANE_W +: IDX_W];

  ahb_lane_strobe #(.data_size(data_size)) u_strb (
    .size_i (size_q),
    .addr_i (addr_q[LANE_W-1:0]),
    .strb_o (strb)
  );

  // Next state: finish the current data phase, then evaluate any new address phase.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    size_d  = size_q;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q <= 3'd1) state_d = ST_DATA;
        else               cnt_d   = cnt_q - 3'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      addr_d = H_add[BADDR_W-1:0];
      wr_d   = H_WR;
      size_d = H_size;
      cnt_d  = 3'(wait_states);
      if (acc_err)               state_d = ST_ERR1;
      else if (wait_states == 0) state_d = ST_DATA;
      else                       state_d = ST_WAIT;
    end
  end

  // State and latched address-phase registers.
  always_ff @(posedge H_clk) begin
    if (H_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
    end
  end

  // Commit enabled byte lanes at the edge that ends a write data phase.
  always_ff @(posedge H_clk) begin
    if (!H_rst && state_q == ST_DATA && wr_q) begin
      for (int b = 0; b < LANES; b++)
        if (strb[b]) mem_q[idx][8*b +: 8] <= W_data[8*b +: 8];
    end
  end

  // Ready/response are pure state decodes.
  always_comb begin
    H_readyN = 1'b1;
    H_rsp    = HRESP_OKAY;
    case (state_q)
      ST_WAIT: H_readyN = 1'b0;
      ST_ERR1: begin
        H_readyN = 1'b0;
        H_rsp    = HRESP_ERROR;
      end
      ST_ERR2: H_rsp = HRESP_ERROR;
      default: ;
    endcase
  end

  // Full word on reads; the master picks the lanes it asked for.
  assign R_data = (state_q == ST_DATA && !wr_q) ? mem_q[idx] : '0;

endmodule

// File: tb/tb_ahb_lite_slave_mem.sv
// Three responders (0, 2, 3 wait states) on one shared AHB-Lite bus, checked
// every cycle against a transfer-level model plus literal directed expectations.
module tb_ahb_lite_slave_mem;
  import ahb_lite_pkg::*;

  localparam int NI    = 3;
  localparam int DEPTH = 256;
  localparam int WS [NI] = '{0, 2, 3};

  logic        H_clk = 1'b0;
  logic        H_rst = 1'b1;
  logic [2:0]  sel = '0;
  logic        H_readyIn = 1'b1;
  logic [31:0] H_add = '0;
  logic        H_WR = 1'b0;
  logic [2:0]  H_size = '0;
  logic [2:0]  H_burst = '0;
  logic [1:0]  H_trans = '0;
  logic [31:0] W_data = '0;
  logic [31:0] rdata [NI];
  logic [2:0]  readyN, rsp;

  always #5 H_clk = ~H_clk;

  ahb_lite_slave_mem #(.data_size(32), .mem_depth(DEPTH), .wait_states(WS[0])) u0 (
    .H_clk(H_clk), .H_rst(H_rst), .H_sel(sel[0]), .H_readyIn(H_readyIn), .H_add(H_add),
    .H_WR(H_WR), .H_size(H_size), .H_burst(H_burst), .H_trans(H_trans), .W_data(W_data),
    .R_data(rdata[0]), .H_readyN(readyN[0]), .H_rsp(rsp[0]));
  ahb_lite_slave_mem #(.data_size(32), .mem_depth(DEPTH), .wait_states(WS[1])) u1 (
    .H_clk(H_clk), .H_rst(H_rst), .H_sel(sel[1]), .H_readyIn(H_readyIn), .H_add(H_add),
    .H_WR(H_WR), .H_size(H_size), .H_burst(H_burst), .H_trans(H_trans), .W_data(W_data),
    .R_data(rdata[1]), .H_readyN(readyN[1]), .H_rsp(rsp[1]));
  ahb_lite_slave_mem #(.data_size(32), .mem_depth(DEPTH), .wait_states(WS[2])) u2 (
    .H_clk(H_clk), .H_rst(H_rst), .H_sel(sel[2]), .H_readyIn(H_readyIn), .H_add(H_add),
    .H_WR(H_WR), .H_size(H_size), .H_burst(H_burst), .H_trans(H_trans), .W_data(W_data),
    .R_data(rdata[2]), .H_readyN(readyN[2]), .H_rsp(rsp[2]));

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  bit stall_en = 1'b0;
  logic [31:0] ap_wdata = '0;

  // Model: memory image plus the one transfer each responder is serving.
  logic [31:0] mm [NI][DEPTH];
  bit          active [NI];
  bit          a_wr [NI];
  bit          a_err [NI];
  logic [31:0] a_addr [NI];
  logic [2:0]  a_size [NI];
  logic [31:0] a_wdata [NI];
  int          phase [NI];
  bit          lst;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void chk1(string name, logic act, logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endfunction

  function automatic bit is_err(logic [31:0] a, logic [2:0] sz);
    int unsigned nb;
    nb = 32'd1 << sz;
    return (nb > 4) || ((a % nb) != 0) || (a >= 32'(DEPTH * 4));
  endfunction

  function automatic void commit(int k, logic [31:0] a, logic [2:0] sz, logic [31:0] wd);
    for (int b = 0; b < (1 << sz); b++) begin
      int unsigned ba;
      ba = a + 32'(b);
      mm[k][ba / 4][8*(ba % 4) +: 8] = wd[8*(ba % 4) +: 8];
    end
  endfunction

  // An OKAY transfer lasts WS+1 cycles (last one ready); ERROR lasts two.
  function automatic bit m_last(int k);
    if (!active[k]) return 1'b0;
    return a_err[k] ? (phase[k] == 1) : (phase[k] == WS[k]);
  endfunction

  function automatic bit m_ready(int k);
    return !active[k] || m_last(k);
  endfunction

  function automatic bit m_rsp(int k);
    return active[k] && a_err[k];
  endfunction

  function automatic logic [31:0] m_rdata(int k);
    if (active[k] && !a_err[k] && !a_wr[k] && m_last(k)) return mm[k][a_addr[k][9:2]];
    return '0;
  endfunction

  function automatic bit bus_ready();
    bit r;
    r = 1'b1;
    for (int k = 0; k < NI; k++) r &= m_ready(k);
    return r;
  endfunction

  function automatic bit any_active();
    bit r;
    r = 1'b0;
    for (int k = 0; k < NI; k++) r |= active[k];
    return r;
  endfunction

  function automatic logic [31:0] peek(int k, logic [7:0] i);
    case (k)
      0:       return u0.mem_q[i];
      1:       return u1.mem_q[i];
      default: return u2.mem_q[i];
    endcase
  endfunction

  task automatic poke(int k, logic [7:0] i, logic [31:0] v);
    case (k)
      0:       u0.mem_q[i] = v;
      1:       u1.mem_q[i] = v;
      default: u2.mem_q[i] = v;
    endcase
    mm[k][i] = v;
  endtask

  // Model advance at each rising edge.
  initial forever begin
    @(posedge H_clk);
    for (int k = 0; k < NI; k++) begin
      if (H_rst) begin
        active[k] = 1'b0;
        phase[k]  = 0;
      end else begin
        lst = m_last(k);
        if (lst && !a_err[k] && a_wr[k]) commit(k, a_addr[k], a_size[k], W_data);
        if (active[k] && !lst) phase[k]++;
        else begin
          active[k] = 1'b0;
          phase[k]  = 0;
          if (sel[k] && H_readyIn && H_trans[1]) begin
            active[k]  = 1'b1;
            a_addr[k]  = H_add;
            a_wr[k]    = H_WR;
            a_size[k]  = H_size;
            a_err[k]   = is_err(H_add, H_size);
            a_wdata[k] = ap_wdata;
          end
        end
      end
    end
  end

  // Per-cycle output comparison, away from the rising edge.
  initial forever begin
    @(negedge H_clk);
    if (chk_en) begin
      for (int k = 0; k < NI; k++) begin
        chk1($sformatf("cyc_ready%0d", k), readyN[k], m_ready(k));
        chk1($sformatf("cyc_rsp%0d", k), rsp[k], m_rsp(k));
        chk($sformatf("cyc_rdata%0d", k), rdata[k], m_rdata(k));
      end
    end
  end

  // One bus cycle: advance, then present data-phase W_data and bus HREADY.
  task automatic tick();
    @(posedge H_clk);
    #1;
    W_data = $urandom;
    for (int k = 0; k < NI; k++)
      if (active[k] && a_wr[k] && !a_err[k]) W_data = a_wdata[k];
    H_readyIn = bus_ready() & ~(stall_en && !any_active() && ($urandom % 8 == 0));
    sel       = '0;
    H_trans   = HTRANS_IDLE;
  endtask

  task automatic addr_phase(int k, logic [1:0] tr, logic [31:0] a, logic wr,
                            logic [2:0] sz, logic [31:0] wd);
    int n;
    n = 0;
    while (!bus_ready() && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      n_chk++;
      n_fail++;
      $display("FAIL addr_wait: ready not seen within %0d cycles, need 1", n);
    end
    sel      = 3'(1 << k);
    H_trans  = tr;
    H_add    = a;
    H_WR     = wr;
    H_size   = sz;
    ap_wdata = wd;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit hit, need completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int unsigned lo, r;
    logic [2:0] sz;

    for (int k = 0; k < NI; k++) begin
      active[k] = 1'b0;
      phase[k]  = 0;
    end
    tick();
    for (int k = 0; k < NI; k++)
      for (int i = 0; i < DEPTH; i++) poke(k, 8'(i), $urandom);
    chk_en = 1'b1;
    tick();
    H_rst = 1'b0;

    // Reset state
    chk("rst_ready", 32'(readyN), 32'h7);
    chk("rst_rsp", 32'(rsp), 32'h0);
    chk("rst_rdata", rdata[0], 32'h0);

    // Zero-wait write then back-to-back read of the same word
    H_burst = HBURST_SINGLE;
    addr_phase(0, HTRANS_NONSEQ, 32'h10, 1'b1, HSIZE_WORD, 32'hDEAD_BEEF);
    chk1("wr_ready", readyN[0], 1'b1);
    addr_phase(0, HTRANS_NONSEQ, 32'h10, 1'b0, HSIZE_WORD, 32'h0);
    chk("rd_after_wr", rdata[0], 32'hDEAD_BEEF);
    chk1("rd_rsp", rsp[0], 1'b0);
    tick();

    // Byte lane write
    poke(0, 8'd4, 32'h1122_3344);
    addr_phase(0, HTRANS_NONSEQ, 32'h12, 1'b1, HSIZE_BYTE, 32'h0055_0000);
    addr_phase(0, HTRANS_NONSEQ, 32'h10, 1'b0, HSIZE_WORD, 32'h0);
    chk("byte_lane", rdata[0], 32'h1155_3344);
    tick();

    // Two wait states
    poke(1, 8'd8, 32'hCAFE_0020);
    addr_phase(1, HTRANS_NONSEQ, 32'h20, 1'b0, HSIZE_WORD, 32'h0);
    cnt = 0;
    while (readyN[1] == 1'b0 && cnt < 20) begin
      cnt++;
      tick();
    end
    chk("wait_cycles", 32'(cnt), 32'd2);
    chk("wait_rdata", rdata[1], 32'hCAFE_0020);
    tick();

    // ERROR: misaligned word write, then out-of-range read
    poke(0, 8'd0, 32'h0BAD_F00D);
    addr_phase(0, HTRANS_NONSEQ, 32'h402, 1'b1, HSIZE_WORD, 32'hFFFF_FFFF);
    chk("err1_a", {30'b0, readyN[0], rsp[0]}, 32'b01);
    tick();
    chk("err2_a", {30'b0, readyN[0], rsp[0]}, 32'b11);
    addr_phase(0, HTRANS_NONSEQ, 32'h400, 1'b0, HSIZE_WORD, 32'h0);
    chk("err1_b", {30'b0, readyN[0], rsp[0]}, 32'b01);
    tick();
    chk("err2_b", {30'b0, readyN[0], rsp[0]}, 32'b11);
    tick();
    chk("err_nowrite", peek(0, 8'd0), 32'h0BAD_F00D);

    // INCR4 with a BUSY beat
    poke(0, 8'd18, 32'h0);
    H_burst = HBURST_INCR4;
    addr_phase(0, HTRANS_NONSEQ, 32'h40, 1'b1, HSIZE_WORD, 32'hA000_0000);
    addr_phase(0, HTRANS_SEQ,    32'h44, 1'b1, HSIZE_WORD, 32'hA000_0001);
    addr_phase(0, HTRANS_BUSY,   32'h48, 1'b1, HSIZE_WORD, 32'h0);
    chk("busy_idle", {30'b0, readyN[0], rsp[0]}, 32'b10);
    chk("busy_nowrite", peek(0, 8'd18), 32'h0);
    addr_phase(0, HTRANS_SEQ,    32'h48, 1'b1, HSIZE_WORD, 32'hA000_0002);
    addr_phase(0, HTRANS_SEQ,    32'h4C, 1'b1, HSIZE_WORD, 32'hA000_0003);
    tick();
    H_burst = HBURST_SINGLE;
    for (int i = 0; i < 4; i++)
      chk($sformatf("incr4_w%0d", i), peek(0, 8'(16 + i)), 32'hA000_0000 + 32'(i));

    // Reset during the second wait cycle (3 wait states)
    poke(2, 8'd12, 32'h1234_5678);
    addr_phase(2, HTRANS_NONSEQ, 32'h30, 1'b1, HSIZE_WORD, 32'hFFFF_0000);
    tick();
    H_rst = 1'b1;
    tick();
    H_rst = 1'b0;
    chk1("rst_wait_ready", readyN[2], 1'b1);
    repeat (4) tick();
    chk("rst_wait_mem", peek(2, 8'd12), 32'h1234_5678);

    // Randomised traffic across all three responders
    stall_en = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      sz = ($urandom % 10 == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      lo = $urandom % 4;
      if ($urandom % 4 != 0 && sz < 3) lo = lo & ~((32'd1 << sz) - 1);
      r = $urandom % 16;
      if (r == 0)      H_add = $urandom;
      else if (r == 1) H_add = 32'(1020 + lo);
      else if (r == 2) H_add = 32'(1024 + lo);
      else             H_add = 32'(($urandom % 16) * 4 + lo);
      H_size   = sz;
      H_WR     = 1'($urandom);
      H_burst  = 3'($urandom);
      ap_wdata = $urandom;
      sel      = ($urandom % 10 == 0) ? 3'b0 : 3'(1 << $urandom_range(0, 2));
      case ($urandom % 8)
        0:       H_trans = HTRANS_IDLE;
        1:       H_trans = HTRANS_BUSY;
        2, 3, 4: H_trans = HTRANS_NONSEQ;
        default: H_trans = HTRANS_SEQ;
      endcase
      H_rst = ($urandom % 150 == 0);
      tick();
    end
    H_rst    = 1'b0;
    stall_en = 1'b0;
    repeat (12) tick();

    // Whole-memory image against the model
    for (int k = 0; k < NI; k++)
      for (int i = 0; i < DEPTH; i++)
        chk($sformatf("mem%0d[%0d]", k, i), peek(k, 8'(i)), mm[k][i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
